// File: rtl/toggle_counter.sv
// Toggle / up / down counter with parallel load, terminal-count pulse and sticky boundary flag.
// Latency: one clk edge from sampled inputs to q/tc/ovf; all outputs come straight from registers.
// Backpressure: none; every enabled edge performs its action unconditionally.
module toggle_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_at_top;
    logic             w_at_zero;
    mode_e            w_mode;

    assign w_mode    = mode_e'(mode);
    // Up-count boundary uses >= so a limit lowered below q still wraps/parks at once.
    assign w_at_top  = (r_q >= limit);
    assign w_at_zero = (r_q == ZERO);

    // Next-state selection: load beats the enable gate, which beats the mode action.
    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (load) begin
            w_q_nxt = d;
        end else if (en) begin
            case (w_mode)
                MODE_HOLD: begin
                    w_q_nxt = r_q;
                end
                MODE_TOGGLE: begin
                    w_q_nxt = r_q ^ t;
                end
                MODE_UP: begin
                    if (w_at_top) begin
                        w_tc_nxt = 1'b1;
                        w_q_nxt  = SATURATE ? limit : ZERO;
                    end else begin
                        w_q_nxt = r_q + ONE;
                    end
                end
                MODE_DOWN: begin
                    if (w_at_zero) begin
                        w_tc_nxt = 1'b1;
                        w_q_nxt  = SATURATE ? ZERO : limit;
                    end else begin
                        w_q_nxt = r_q - ONE;
                    end
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
        end
    end

    // Sticky flag: a boundary hit on this edge wins over a simultaneous clear.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_tc_nxt) begin
            w_ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_nxt = 1'b0;
        end
    end

    // State registers with asynchronous reset to all-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= ZERO;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_tc  <= w_tc_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_toggle_counter.sv
// Self-checking bench: two WIDTH=4 instances (wrap and saturate) share stimulus.
// Directed scenarios for the documented examples, then randomized traffic vs a reference model.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_toggle_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] limit;
    logic         clr_ovf;

    logic [W-1:0] q0, q1;
    logic         tc0, tc1, ovf0, ovf1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, index 0 = wrap instance, 1 = saturate instance.
    int m_q   [2];
    int m_tc  [2];
    int m_ovf [2];

    toggle_counter #(.WIDTH(W), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .load(load),
        .d(d), .limit(limit), .clr_ovf(clr_ovf), .q(q0), .tc(tc0), .ovf(ovf0)
    );

    toggle_counter #(.WIDTH(W), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t), .load(load),
        .d(d), .limit(limit), .clr_ovf(clr_ovf), .q(q1), .tc(tc1), .ovf(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural rules: counts are plain integer arithmetic modulo 16.
    function automatic void model_edge(int s);
        int nq;
        int ntc;
        nq  = m_q[s];
        ntc = 0;
        if (load) begin
            nq = int'(d);
        end else if (en) begin
            if (mode == 2'd1) begin
                nq = m_q[s] ^ int'(t);
            end else if (mode == 2'd2) begin
                if (m_q[s] >= int'(limit)) begin
                    ntc = 1;
                    nq  = (s == 1) ? int'(limit) : 0;
                end else begin
                    nq = (m_q[s] + 1) % 16;
                end
            end else if (mode == 2'd3) begin
                if (m_q[s] == 0) begin
                    ntc = 1;
                    nq  = (s == 1) ? 0 : int'(limit);
                end else begin
                    nq = m_q[s] - 1;
                end
            end
        end
        if (ntc == 1)      m_ovf[s] = 1;
        else if (clr_ovf)  m_ovf[s] = 0;
        m_q[s]  = nq;
        m_tc[s] = ntc;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_q[s] = 0; m_tc[s] = 0; m_ovf[s] = 0;
        end
    endfunction

    task automatic check_model();
        check("q0",   32'(q0),   32'(m_q[0]));
        check("tc0",  32'(tc0),  32'(m_tc[0]));
        check("ovf0", 32'(ovf0), 32'(m_ovf[0]));
        check("q1",   32'(q1),   32'(m_q[1]));
        check("tc1",  32'(tc1),  32'(m_tc[1]));
        check("ovf1", 32'(ovf1), 32'(m_ovf[1]));
    endtask

    // One rising edge: advance the model with the sampled inputs, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_model();
    endtask

    // Reset pulse entirely between rising edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_q0"},   32'(q0),   32'd0);
        check({tag, "_tc0"},  32'(tc0),  32'd0);
        check({tag, "_ovf0"}, 32'(ovf0), 32'd0);
        check({tag, "_q1"},   32'(q1),   32'd0);
        check({tag, "_ovf1"}, 32'(ovf1), 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; t = '0; load = 1'b0;
        d = '0; limit = '0; clr_ovf = 1'b0;
        model_reset();
        #12;
        check("rst_q0", 32'(q0), 32'd0);
        check("rst_tc0", 32'(tc0), 32'd0);
        check("rst_ovf1", 32'(ovf1), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Toggle: load 0101, toggle mask 0011 twice.
        load = 1'b1; d = 4'b0101; step();
        load = 1'b0; mode = 2'd1; t = 4'b0011; en = 1'b1;
        step(); check("tog_q_a", 32'(q0), 32'b0110); check("tog_tc_a", 32'(tc0), 32'd0);
        step(); check("tog_q_b", 32'(q0), 32'b0101); check("tog_tc_b", 32'(tc0), 32'd0);

        // Up wrap with limit 5 starting from 3.
        load = 1'b1; d = 4'd3; limit = 4'd5; step();
        load = 1'b0; mode = 2'd2; en = 1'b1;
        step(); check("up_q1", 32'(q0), 32'd4); check("up_tc1", 32'(tc0), 32'd0);
        step(); check("up_q2", 32'(q0), 32'd5); check("up_tc2", 32'(tc0), 32'd0);
        step(); check("up_q3", 32'(q0), 32'd0); check("up_tc3", 32'(tc0), 32'd1);
        check("up_ovf3", 32'(ovf0), 32'd1);
        step(); check("up_q4", 32'(q0), 32'd1); check("up_tc4", 32'(tc0), 32'd0);
        check("up_ovf4", 32'(ovf0), 32'd1);

        // Load priority over a disabled count, with clear of a set sticky flag.
        load = 1'b1; d = 4'b0101; step();
        check("pri_ovf_pre", 32'(ovf0), 32'd1);
        d = 4'b1110; en = 1'b0; mode = 2'd2; clr_ovf = 1'b1; step();
        check("pri_q", 32'(q0), 32'b1110); check("pri_tc", 32'(tc0), 32'd0);
        check("pri_ovf", 32'(ovf0), 32'd0);
        clr_ovf = 1'b0;

        // Down count into a saturating floor.
        load = 1'b1; d = 4'd1; limit = 4'd9; step();
        load = 1'b0; mode = 2'd3; en = 1'b1;
        step(); check("dn_q1", 32'(q1), 32'd0); check("dn_tc1", 32'(tc1), 32'd0);
        step(); check("dn_q2", 32'(q1), 32'd0); check("dn_tc2", 32'(tc1), 32'd1);
        step(); check("dn_q3", 32'(q1), 32'd0); check("dn_tc3", 32'(tc1), 32'd1);
        check("dn_ovf", 32'(ovf1), 32'd1);

        // Boundary set beats a simultaneous clear.
        load = 1'b1; d = 4'd7; limit = 4'd7; step();
        load = 1'b0; mode = 2'd2; en = 1'b1; clr_ovf = 1'b1; step();
        check("sbc_q", 32'(q0), 32'd0); check("sbc_tc", 32'(tc0), 32'd1);
        check("sbc_ovf", 32'(ovf0), 32'd1);
        clr_ovf = 1'b0;

        // Asynchronous reset mid-count, then the first edge counts immediately.
        load = 1'b1; d = 4'd10; limit = 4'd15; step();
        load = 1'b0; mode = 2'd2; en = 1'b1; step();
        check("ar_pre_q", 32'(q0), 32'd11);
        async_reset("ar");
        step(); check("ar_post_q", 32'(q0), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom_range(0, 3));
            t       = 4'($urandom);
            load    = ($urandom_range(0, 7) == 0);
            d       = 4'($urandom);
            clr_ovf = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) begin
                limit = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
            end
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rnd_ar");
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
